div_seq_ctrl: RTL

Multi-cycle division sequencer for the EXE stage. It accepts one DIV.W/MOD.W/DIV.WU/MOD.WU operation at a time, runs a fixed 32-iteration restoring divide on operand magnitudes and applies sign correction. It holds the result until the stage hands it to MEM, and generates the per-op ready signal the EXE stage uses as its division ready_go. Flushes on exception/ertn so a killed instruction never leaves the divider busy.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_iter_step.sv | 23 ++
 rtl/div_seq_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared encodings for the EXE-stage division sequencer.
package div_pkg;

    localparam int DIV_ITER = 32;

    typedef enum logic [1:0] {
        OP_DIV_W  = 2'b00,
        OP_MOD_W  = 2'b01,
        OP_DIV_WU = 2'b10,
        OP_MOD_WU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when the trial remainder is large enough.
module div_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             msb_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] trial;

    // The true difference is always below the divisor, so WIDTH-bit modular
    // subtraction gives the exact remainder.
    always_comb begin
        trial   = {rem_i, msb_i};
        q_bit_o = (trial >= {1'b0, divisor_i});
        rem_o   = q_bit_o ? (trial[WIDTH-1:0] - divisor_i) : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle DIV.W/MOD.W/DIV.WU/MOD.WU sequencer: 32 restoring steps on
// operand magnitudes, sign correction, result held until EXE advances.
//
// state  | meaning
// S_IDLE | no op in flight, waiting for start
// S_BUSY | one restoring step per cycle, cnt counts steps
// S_DONE | result valid and held until out_accept
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_ITER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             out_accept,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    div_state_e       state_q;
    div_op_e          op_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] result_q;
    logic             qsign_q;
    logic             rsign_q;

    logic [WIDTH-1:0] rem_d;
    logic             q_bit;
    logic             take;
    logic             in_signed;
    logic             sign1;
    logic             sign2;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic             op_signed_q;
    logic             op_mod_q;
    logic [WIDTH-1:0] quot_raw;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] result_d;

    div_iter_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .msb_i     (dvd_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (rem_d),
        .q_bit_o   (q_bit)
    );

    always_comb begin
        take = start && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_accept));

        in_signed = (div_op_e'(op) == OP_DIV_W) || (div_op_e'(op) == OP_MOD_W);
        sign1     = in_signed && src1[WIDTH-1];
        sign2     = in_signed && src2[WIDTH-1];
        mag1      = sign1 ? (~src1 + 1'b1) : src1;
        mag2      = sign2 ? (~src2 + 1'b1) : src2;

        op_signed_q = (op_q == OP_DIV_W) || (op_q == OP_MOD_W);
        op_mod_q    = (op_q == OP_MOD_W) || (op_q == OP_MOD_WU);

        // Final step: the dividend register has become the quotient shift register.
        quot_raw = {dvd_q[WIDTH-2:0], q_bit};
        quot_fix = (op_signed_q && qsign_q) ? (~quot_raw + 1'b1) : quot_raw;
        rem_fix  = (op_signed_q && rsign_q) ? (~rem_d + 1'b1) : rem_d;
        result_d = op_mod_q ? rem_fix : quot_fix;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_DIV_W;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
        end else if (flush) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else if (take) begin
            state_q <= S_BUSY;
            op_q    <= div_op_e'(op);
            cnt_q   <= '0;
            dvd_q   <= mag1;
            dvs_q   <= mag2;
            rem_q   <= '0;
            qsign_q <= sign1 ^ sign2;
            rsign_q <= sign1;
        end else begin
            unique case (state_q)
                S_IDLE: ;
                S_BUSY: begin
                    rem_q <= rem_d;
                    dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        result_q <= result_d;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_accept) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule
